// File: rtl/sal_ref_sched.sv
// sal_ref_sched: DDR2 auto-refresh scheduler; counts tREFI, holds postponed-refresh credit,
// arbitrates for the command bus and sequences PREA -> tRP -> REF -> tRFC.
module sal_ref_sched #(
  parameter int REFI_CYCLES = 1560,
  parameter int CNT_W       = 12,
  parameter int MAX_PEND    = 8,
  parameter int URGENT_TH   = 6,
  parameter int RP_W        = 4,
  parameter int RFC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_en,
  input  logic [RP_W-1:0]  t_rp_m1,
  input  logic [RFC_W-1:0] t_rfc_m1,
  output logic             ref_req,
  output logic             ref_urgent,
  input  logic             ref_gnt,
  output logic             ref_busy,
  output logic             cmd_valid,
  output logic             cmd_is_ref,
  input  logic             cmd_ready,
  output logic [3:0]       pend_cnt,
  output logic             ref_err
);
  localparam int TW = RP_W > RFC_W ? RP_W : RFC_W;
  typedef enum logic [2:0] {IDLE, REQ, PREA, WAIT_RP, REF, WAIT_RFC} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pend, w_pend;
  logic [TW-1:0]    r_tmr, w_tmr;
  logic             r_err, w_tick, w_ref_hs;
  assign w_tick   = ref_en && r_cnt == CNT_W'(REFI_CYCLES - 1);
  assign w_ref_hs = r_state == REF && cmd_ready;
  assign w_pend   = (w_tick && !w_ref_hs) ? (r_pend == 4'(MAX_PEND) ? r_pend : r_pend + 4'd1) :
                    (w_ref_hs && !w_tick) ? r_pend - 4'd1 : r_pend;
  // Timers load m1-1 so the next command lands exactly m1+1 cycles after the handshake.
  always_comb begin
    w_next = r_state;
    w_tmr  = r_tmr;
    case (r_state)
      IDLE:     w_next = r_pend != 4'd0 ? REQ : IDLE;
      REQ:      w_next = ref_gnt ? PREA : REQ;
      PREA:     if (cmd_ready) begin
                  w_next = t_rp_m1 == '0 ? REF : WAIT_RP;
                  w_tmr  = TW'(t_rp_m1) - TW'(1);
                end
      WAIT_RP:  begin
                  w_next = r_tmr == '0 ? REF : WAIT_RP;
                  w_tmr  = r_tmr - TW'(1);
                end
      REF:      if (cmd_ready) begin
                  w_next = t_rfc_m1 == '0 ? IDLE : WAIT_RFC;
                  w_tmr  = TW'(t_rfc_m1) - TW'(1);
                end
      WAIT_RFC: begin
                  w_next = r_tmr == '0 ? IDLE : WAIT_RFC;
                  w_tmr  = r_tmr - TW'(1);
                end
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_tmr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmr   <= w_tmr;
      r_pend  <= w_pend;
      r_cnt   <= (!ref_en || w_tick) ? '0 : r_cnt + CNT_W'(1);
      r_err   <= r_err | (w_tick && !w_ref_hs && r_pend == 4'(MAX_PEND));
    end
  end
  assign ref_req    = r_state == REQ;
  assign ref_urgent = r_pend >= 4'(URGENT_TH);
  assign ref_busy   = r_state inside {PREA, WAIT_RP, REF, WAIT_RFC};
  assign cmd_valid  = r_state == PREA || r_state == REF;
  assign cmd_is_ref = r_state == REF;
  assign pend_cnt   = r_pend;
  assign ref_err    = r_err;
endmodule
